// File: rtl/mw_cook_timer.sv
// Microwave cook-time controller: BCD MM:SS keypad entry, countdown while the
// oven heats, hold on pause, and a level finish flag on expiry.
module mw_cook_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        heat,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  output logic        finish,
  output logic        armed,
  output logic        running,
  output logic [15:0] disp_time
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     time_q, time_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            key_ok_s;
  logic [15:0]     shifted_s;
  logic [15:0]     dec_s;

  // Two-digit BCD decrement with ones/tens borrow; caller guarantees v != 00.
  function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd0) begin
      r = {v[7:4], v[3:0] - 4'd1};
    end else begin
      r = {v[7:4] - 4'd1, 4'd9};
    end
    return r;
  endfunction

  // One-second decrement of MM:SS; seconds may exceed 59 after entry, so only
  // the minute borrow reloads 59. Saturates at 0000.
  function automatic logic [15:0] time_dec(input logic [15:0] t);
    logic [15:0] r;
    if (t[7:0] != 8'h00) begin
      r = {t[15:8], bcd2_dec(t[7:0])};
    end else if (t[15:8] != 8'h00) begin
      r = {bcd2_dec(t[15:8]), 8'h59};
    end else begin
      r = 16'h0000;
    end
    return r;
  endfunction

  // Next-state, time and prescaler computation.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    presc_d   = presc_q;
    key_ok_s  = key_valid && (key_digit <= 4'd9);
    shifted_s = {time_q[11:0], key_digit};
    dec_s     = time_dec(time_q);

    case (state_q)
      S_IDLE: begin
        if (heat) begin
          state_d = S_DONE;
          time_d  = 16'h0000;
          presc_d = '0;
        end else if (key_clear) begin
          time_d = 16'h0000;
        end else if (key_ok_s) begin
          time_d = shifted_s;
          if (shifted_s != 16'h0000) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (heat) begin
          state_d = S_RUN;
          presc_d = '0;
        end else if (key_clear) begin
          state_d = S_IDLE;
          time_d  = 16'h0000;
        end else if (key_ok_s) begin
          time_d = shifted_s;
          if (shifted_s == 16'h0000) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          state_d = S_ARMED;
        end
      end
      S_RUN: begin
        if (heat) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            time_d  = dec_s;
            if (dec_s == 16'h0000) begin
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end else begin
          // Paused: the partial second in the prescaler is kept.
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        time_d  = 16'h0000;
        presc_d = '0;
        if (!heat) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        time_d  = 16'h0000;
        presc_d = '0;
      end
    endcase
  end

  // State, time and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      time_q  <= 16'h0000;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      presc_q <= presc_d;
    end
  end

  assign finish    = (state_q == S_DONE);
  assign armed     = (state_q == S_ARMED);
  assign running   = (state_q == S_RUN);
  assign disp_time = time_q;

endmodule

// File: tb/tb_mw_cook_timer.sv
// Directed self-checking bench for mw_cook_timer with TICKS_PER_SEC = 4.
module tb_mw_cook_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        heat = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_clear = 1'b0;
  logic        finish, armed, running;
  logic [15:0] disp_time;

  int n_checks = 0;
  int n_fail   = 0;

  mw_cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .heat      (heat),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .key_clear (key_clear),
    .finish    (finish),
    .armed     (armed),
    .running   (running),
    .disp_time (disp_time)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic clear_key();
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] t,
                            input logic f, input logic a, input logic r);
    check_eq({tag, "_disp"}, disp_time, t);
    check_eq({tag, "_finish"}, 16'(finish), 16'(f));
    check_eq({tag, "_armed"}, 16'(armed), 16'(a));
    check_eq({tag, "_running"}, 16'(running), 16'(r));
  endtask

  // Assert reset between clock edges, check outputs before any edge, release.
  task automatic mid_reset(input string tag);
    heat = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outs(tag, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  // Enter four digits, heat for one transition edge plus one second, then check.
  task automatic one_second(input string tag, input logic [15:0] entry, input logic [15:0] exp);
    for (int i = 3; i >= 0; i--) press(entry[i*4 +: 4]);
    check_eq({tag, "_entry"}, disp_time, entry);
    heat = 1'b1;
    step();
    check_eq({tag, "_run"}, 16'(running), 16'd1);
    step(4);
    check_eq({tag, "_dec"}, disp_time, exp);
    mid_reset({tag, "_rst"});
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step();
    check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Entry
    press(4'd1);
    press(4'd2);
    check_outs("entry12", 16'h0012, 1'b0, 1'b1, 1'b0);
    press(4'hA);
    check_eq("key_a_ignored", disp_time, 16'h0012);
    press(4'd3);
    press(4'd4);
    press(4'd5);
    check_eq("entry2345", disp_time, 16'h2345);
    clear_key();
    check_outs("clear", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Shifting out the top digit to zero returns to IDLE
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    check_eq("entry1000", disp_time, 16'h1000);
    press(4'd0);
    check_outs("shift_out", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Clear beats a simultaneous key
    press(4'd7);
    key_clear = 1'b1;
    press(4'd8);
    key_clear = 1'b0;
    check_outs("clear_beats_key", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Countdown
    press(4'd0);
    press(4'd2);
    check_outs("arm0002", 16'h0002, 1'b0, 1'b1, 1'b0);
    heat = 1'b1;
    step();
    check_outs("run_start", 16'h0002, 1'b0, 1'b0, 1'b1);
    step(3);
    check_eq("run_edge3", disp_time, 16'h0002);
    step();
    check_eq("run_edge4", disp_time, 16'h0001);
    step(4);
    check_outs("expire", 16'h0000, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("done_hold", 16'(finish), 16'd1);
    heat = 1'b0;
    step();
    check_outs("finish_drop", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Pause
    press(4'd1);
    heat = 1'b1;
    step(3);
    heat = 1'b0;
    step(10);
    check_outs("paused", 16'h0001, 1'b0, 1'b0, 1'b1);
    heat = 1'b1;
    step();
    check_eq("resume1", 16'(finish), 16'd0);
    step();
    check_outs("resume2", 16'h0000, 1'b1, 1'b0, 1'b0);
    heat = 1'b0;
    step();

    // Heat in ARMED ignores a same-cycle key
    press(4'd3);
    heat = 1'b1;
    press(4'd5);
    check_outs("armed_heat_key", 16'h0003, 1'b0, 1'b0, 1'b1);
    mid_reset("rst_mid_run");

    // Borrow
    one_second("b0100", 16'h0100, 16'h0059);
    one_second("b0090", 16'h0090, 16'h0089);
    one_second("b1000", 16'h1000, 16'h0959);

    // Zero start; heat beats a simultaneous key in IDLE
    heat = 1'b1;
    press(4'd6);
    check_outs("zero_start", 16'h0000, 1'b1, 1'b0, 1'b0);
    heat = 1'b0;
    step();
    check_eq("zero_start_drop", 16'(finish), 16'd0);

    // Heat drops right at expiry, then resumes
    press(4'd1);
    heat = 1'b1;
    step(5);
    check_eq("coinc_expire", 16'(finish), 16'd1);
    heat = 1'b0;
    step();
    check_eq("coinc_idle", 16'(finish), 16'd0);
    heat = 1'b1;
    step();
    check_outs("coinc_reassert", 16'h0000, 1'b1, 1'b0, 1'b0);
    mid_reset("rst_mid_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
